// File: rtl/dmem_responder.sv
// Byte-wide data memory for the Y86-64 M stage; one 64-bit big-endian access per
// request, one byte per clock. Optional macro: DMEM_ALIGN_CHECK_EN (reject addr[2:0]!=0).
// Ports: clk, rst (async, active-high)
//   req_valid/req_ready/req_write/req_addr/req_wdata : request channel
//   rsp_valid/rsp_ready/rsp_rdata/rsp_err            : response channel
module dmem_responder #(
  parameter int unsigned MEM_BYTES = 1048576
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AW = $clog2(MEM_BYTES);
  localparam logic [63:0] LAST_OK = 64'(MEM_BYTES) - 64'd8;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t          state_q;
  logic [2:0]      beat_q;
  logic            write_q;
  logic [AW-1:0]   ptr_q;
  logic [63:0]     wdata_q;
  logic            rsp_valid_q;
  logic [63:0]     rsp_rdata_q;
  logic            rsp_err_q;
  logic            addr_ok_d;

  logic [7:0] mem_q [MEM_BYTES];

  // Last legal start address is compared directly; addr+7 would wrap at 2^64.
  always_comb begin
    addr_ok_d = (req_addr <= LAST_OK);
`ifdef DMEM_ALIGN_CHECK_EN
    if (req_addr[2:0] != 3'd0) addr_ok_d = 1'b0;
`else
`endif
  end

  assign req_ready = (state_q == IDLE) && !rst;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      beat_q      <= 3'd0;
      write_q     <= 1'b0;
      ptr_q       <= '0;
      wdata_q     <= 64'd0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 64'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req_valid) begin
            write_q     <= req_write;
            ptr_q       <= req_addr[AW-1:0];
            wdata_q     <= req_wdata;
            beat_q      <= 3'd0;
            rsp_rdata_q <= 64'd0;
            if (addr_ok_d) begin
              state_q <= ACCESS;
            end else begin
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
            end
          end
        end
        ACCESS: begin
          // MSB byte lives at the lowest address, so shift in/out from the top.
          if (!write_q) begin
            rsp_rdata_q <= {rsp_rdata_q[55:0], mem_q[ptr_q]};
          end
          wdata_q <= {wdata_q[55:0], 8'h00};
          ptr_q   <= ptr_q + AW'(1);
          beat_q  <= beat_q + 3'd1;
          if (beat_q == 3'd7) begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 64'd0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // An async reset forces IDLE before the next edge, which stops a partial write.
  always_ff @(posedge clk) begin
    if (state_q == ACCESS && write_q) begin
      mem_q[ptr_q] <= wdata_q[63:56];
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios plus randomized
// read/write traffic against a byte-level associative-array memory model.
module tb_dmem_responder;

  localparam longint unsigned MEM = 64'd1048576;
`ifdef DMEM_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_rdata;
  logic        rsp_err;

  int compared = 0;
  int mismatched = 0;

  logic [7:0] mem_m [longint unsigned];

  dmem_responder dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;

  function automatic bit m_err(input logic [63:0] a);
    bit ok;
    ok = (a < MEM) && ((MEM - a) >= 64'd8);
    if (ALIGN && (a % 8 != 0)) ok = 1'b0;
    return !ok;
  endfunction

  function automatic logic [63:0] m_read(input logic [63:0] a);
    logic [63:0] v;
    v = 64'd0;
    for (int k = 0; k < 8; k++) v = (v << 8) | 64'(mem_m[a + 64'(k)]);
    return v;
  endfunction

  function automatic void m_write(input logic [63:0] a, input logic [63:0] d);
    for (int k = 0; k < 8; k++) mem_m[a + 64'(k)] = d[8*(7-k) +: 8];
  endfunction

  // Drives one request, counts cycles from the handshake cycle to rsp_valid,
  // then completes the response handshake.
  task automatic xact(input bit w, input logic [63:0] a, input logic [63:0] d,
                      output logic [63:0] rd, output logic er,
                      output int lat, output bit to);
    int n;
    to = 1'b0;
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    req_write = w;
    req_addr = a;
    req_wdata = d;
    n = 0;
    while (!req_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 50) to = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_wdata = ~d;
    lat = 1;
    while (!rsp_valid && lat < 30) begin
      @(posedge clk); #1; lat++;
    end
    if (lat >= 30) to = 1'b1;
    rd = rsp_rdata;
    er = rsp_err;
    @(posedge clk); #1;
  endtask

  task automatic check_op(input string nm, input bit w, input logic [63:0] a,
                          input logic [63:0] d);
    logic [63:0] rd, exp_rd;
    logic er;
    bit exp_er, to;
    int lat, exp_lat;
    exp_er = m_err(a);
    exp_lat = exp_er ? 1 : 9;
    exp_rd = (w || exp_er) ? 64'd0 : m_read(a);
    xact(w, a, d, rd, er, lat, to);
    if (w && !exp_er) m_write(a, d);
    compared++;
    if (to) begin
      mismatched++;
      $display("FAIL %s timeout: addr %h got no response within budget", nm, a);
    end
    compared++;
    if (er !== exp_er) begin
      mismatched++;
      $display("FAIL %s err: addr %h got %b want %b", nm, a, er, exp_er);
    end
    compared++;
    if (lat !== exp_lat) begin
      mismatched++;
      $display("FAIL %s latency: addr %h got %0d want %0d", nm, a, lat, exp_lat);
    end
    compared++;
    if (rd !== exp_rd) begin
      mismatched++;
      $display("FAIL %s rdata: addr %h got %h want %h", nm, a, rd, exp_rd);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr = 64'd0;
    req_wdata = 64'd0;
    rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    compared++;
    if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== 64'd0) begin
      mismatched++;
      $display("FAIL reset_outputs: got v=%b e=%b d=%h want 0 0 0",
               rsp_valid, rsp_err, rsp_rdata);
    end
    compared++;
    if (req_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_ready_in_rst: got %b want 0", req_ready);
    end
    rst = 1'b0;
    #1;
    compared++;
    if (req_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL reset_ready_after: got %b want 1", req_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    check_op("basic_wr", 1'b1, 64'h100, 64'h0123456789ABCDEF);
    check_op("basic_rd", 1'b0, 64'h100, 64'h0);
  endtask

  task automatic test_byte_order();
    logic [63:0] rd;
    logic er;
    int lat;
    bit to;
    check_op("order_wr", 1'b1, 64'h108, 64'h0);
    xact(1'b0, 64'h101, 64'h0, rd, er, lat, to);
    compared++;
    if (ALIGN) begin
      if (er !== 1'b1) begin
        mismatched++;
        $display("FAIL order_rd_align: got err %b want 1", er);
      end
    end else if (rd !== 64'h23456789ABCDEF00 || er !== 1'b0) begin
      mismatched++;
      $display("FAIL order_rd: got %h err %b want 23456789abcdef00 err 0", rd, er);
    end
  endtask

  task automatic test_boundary();
    check_op("bound_wr_last", 1'b1, 64'hFFFF8, 64'h1122334455667788);
    check_op("bound_rd_last", 1'b0, 64'hFFFF8, 64'h0);
    check_op("bound_wr_over", 1'b1, 64'hFFFF9, 64'hAAAAAAAAAAAAAAAA);
    check_op("bound_rd_back", 1'b0, 64'hFFFF8, 64'h0);
    check_op("bound_rd_nowrap", 1'b0, 64'hFFFFFFFFFFFFFFF8, 64'h0);
    check_op("bound_rd_size", 1'b0, MEM, 64'h0);
  endtask

  task automatic test_backpressure();
    logic [63:0] rd0, exp0;
    logic er0;
    int n;
    exp0 = m_read(64'h100);
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr = 64'h100;
    req_wdata = 64'h0;
    n = 0;
    while (!req_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    @(posedge clk); #1;
    req_write = 1'b1;
    req_wdata = 64'hDEADBEEFCAFEF00D;
    n = 0;
    while (!rsp_valid && n < 30) begin
      @(posedge clk); #1; n++;
    end
    rd0 = rsp_rdata;
    er0 = rsp_err;
    compared++;
    if (n >= 30 || rd0 !== exp0 || er0 !== 1'b0) begin
      mismatched++;
      $display("FAIL bp_first: got %h err %b want %h err 0", rd0, er0, exp0);
    end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      compared++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== exp0 || rsp_err !== er0 ||
          req_ready !== 1'b0) begin
        mismatched++;
        $display("FAIL bp_hold%0d: got v=%b d=%h e=%b rdy=%b want 1 %h 0 0",
                 c, rsp_valid, rsp_rdata, rsp_err, req_ready, exp0);
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    compared++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL bp_release: got v=%b rdy=%b want 0 1", rsp_valid, req_ready);
    end
    @(posedge clk); #1;
    compared++;
    if (req_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL bp_next_accept: got rdy=%b want 0", req_ready);
    end
    req_valid = 1'b0;
    m_write(64'h100, 64'hDEADBEEFCAFEF00D);
    n = 0;
    while (!rsp_valid && n < 30) begin
      @(posedge clk); #1; n++;
    end
    compared++;
    if (n >= 30 || rsp_err !== 1'b0) begin
      mismatched++;
      $display("FAIL bp_second_rsp: got v=%b err %b want 1 0", rsp_valid, rsp_err);
    end
    @(posedge clk); #1;
    check_op("bp_readback", 1'b0, 64'h100, 64'h0);
  endtask

  task automatic test_reset_mid_write();
    int n;
    check_op("rmw_clear", 1'b1, 64'h200, 64'h0);
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr = 64'h200;
    req_wdata = 64'hFFFFFFFFFFFFFFFF;
    n = 0;
    while (!req_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    compared++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL rmw_abort: got v=%b rdy=%b want 0 0", rsp_valid, req_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    compared++;
    if (req_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL rmw_ready: got %b want 1", req_ready);
    end
    for (int k = 0; k < 3; k++) mem_m[64'h200 + 64'(k)] = 8'hFF;
    compared++;
    if (m_read(64'h200) !== 64'hFFFFFF0000000000) begin
      mismatched++;
      $display("FAIL rmw_model: got %h want ffffff0000000000", m_read(64'h200));
    end
    check_op("rmw_readback", 1'b0, 64'h200, 64'h0);
  endtask

  task automatic test_align();
    check_op("align_rd_104", 1'b0, 64'h104, 64'h0);
  endtask

  task automatic test_random();
    logic [63:0] a;
    bit w;
    for (int i = 0; i < 32; i++) begin
      check_op("rnd_fill", 1'b1, 64'h1000 + 64'(i * 8), {$urandom, $urandom});
    end
    for (int i = 0; i < 40; i++) begin
      w = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) begin
        a = 64'hFFFF8 + 64'($urandom_range(0, 16));
        if (a != 64'hFFFF8) a = ($urandom_range(0, 1) == 1) ? {$urandom, $urandom} : a;
        if (m_err(a) == 1'b0 && a != 64'hFFFF8) a = 64'hFFFF9;
      end else begin
        a = 64'h1000 + 64'($urandom_range(0, 248));
      end
      check_op("rnd_op", w, a, {$urandom, $urandom});
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_byte_order();
    test_boundary();
    test_backpressure();
    test_reset_mid_write();
    test_align();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
